// File: rtl/bcd_counter_7seg_multi_pkg.sv
// rtl/bcd_counter_7seg_multi_pkg.sv - shared BCD/7-segment definitions and debounce state type
//
// Purpose: segment codes (active-low, bit0=a .. bit6=g), digit/segment widths,
// the debounce FSM state type and a BCD-to-segment decode helper.
// Ports: none (package).
package bcd_counter_7seg_multi_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int SEG_W       = 7;

  localparam logic [SEG_W-1:0] SEG_0      = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1      = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2      = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3      = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4      = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5      = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6      = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7      = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8      = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9      = 7'h10;
  localparam logic [SEG_W-1:0] SEG_BLANK  = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_ALL_ON = 7'h00;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_WAIT,
    DB_HELD,
    DB_RELEASE_WAIT
  } db_state_e;

  // Codes A..F cannot occur in the counter; they decode to blank.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [BCD_DIGIT_W-1:0] d);
    logic [SEG_W-1:0] s;
    s = SEG_BLANK;
    case (d)
      4'd0: s = SEG_0;
      4'd1: s = SEG_1;
      4'd2: s = SEG_2;
      4'd3: s = SEG_3;
      4'd4: s = SEG_4;
      4'd5: s = SEG_5;
      4'd6: s = SEG_6;
      4'd7: s = SEG_7;
      4'd8: s = SEG_8;
      4'd9: s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_counter_7seg_multi_debounce.sv
// rtl/bcd_counter_7seg_multi_debounce.sv - push-button synchroniser and debounce FSM
//
// Purpose: 2-FF synchronises the raw active-low button and debounces it with an
// IDLE/PRESS_WAIT/HELD/RELEASE_WAIT FSM; emits one press pulse per accepted press.
// Ports:
//   clk    in  system clock
//   rst    in  synchronous active-high reset
//   button in  raw active-low button, asynchronous to clk
//   press  out one-cycle pulse on entry to HELD
module button_debounce
  import bcd_counter_7seg_multi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic press
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             btn_low;

  // Synchroniser resets to "released" so a button held through reset
  // has to go through a full debounce period.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], button};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign btn_low = ~sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      DB_IDLE: begin
        if (btn_low) begin
          state_d = DB_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      DB_PRESS_WAIT: begin
        if (!btn_low) begin
          state_d = DB_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_HELD;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DB_HELD: begin
        if (!btn_low) begin
          state_d = DB_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      DB_RELEASE_WAIT: begin
        // A bounce back low returns to HELD without a new pulse.
        if (btn_low) begin
          state_d = DB_HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = DB_IDLE;
    endcase
  end

  assign press = press_q;

endmodule

// File: rtl/bcd_counter_7seg_multi.sv
// rtl/bcd_counter_7seg_multi.sv - debounced N-digit BCD up/down counter with 7-seg outputs
//
// Purpose: counts debounced button presses in BCD (up or down), pulses wrap on
// all-9/all-0 rollover, drives registered active-low 7-seg codes with lamp test.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the highest non-zero digit.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   button      raw active-low push-button
//   enable      1 = presses count
//   up_down     1 = up, 0 = down
//   clear       synchronous counter clear (beats a press)
//   seg7all_on  lamp test
//   count_bcd   4*DIGITS BCD count, digit 0 in the low nibble
//   hex         7*DIGITS active-low segments per digit
//   wrap        one-cycle rollover pulse
module bcd_counter_7seg_multi
  import bcd_counter_7seg_multi_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          button,
  input  logic                          enable,
  input  logic                          up_down,
  input  logic                          clear,
  input  logic                          seg7all_on,
  output logic [BCD_DIGIT_W*DIGITS-1:0] count_bcd,
  output logic [SEG_W*DIGITS-1:0]       hex,
  output logic                          wrap
);

  logic                          press;
  logic [BCD_DIGIT_W*DIGITS-1:0] count_q, count_d;
  logic                          wrap_q, wrap_d;
  logic                          carry;
  logic [BCD_DIGIT_W-1:0]        digit;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .button(button),
    .press (press)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Ripple carry/borrow from digit 0 upward; a carry out of the top digit is the wrap.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    carry   = 1'b1;
    digit   = '0;
    if (clear) begin
      count_d = '0;
    end else if (press && enable) begin
      for (int i = 0; i < DIGITS; i++) begin
        digit = count_q[BCD_DIGIT_W*i +: BCD_DIGIT_W];
        if (carry) begin
          if (up_down) begin
            if (digit == 4'd9) begin
              count_d[BCD_DIGIT_W*i +: BCD_DIGIT_W] = 4'd0;
            end else begin
              count_d[BCD_DIGIT_W*i +: BCD_DIGIT_W] = digit + 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (digit == 4'd0) begin
              count_d[BCD_DIGIT_W*i +: BCD_DIGIT_W] = 4'd9;
            end else begin
              count_d[BCD_DIGIT_W*i +: BCD_DIGIT_W] = digit - 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
      wrap_d = carry;
    end
  end

  assign count_bcd = count_q;
  assign wrap      = wrap_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [SEG_W-1:0] hex_q, hex_d;
`ifdef LEADING_ZERO_BLANK_EN
    logic blank;
    localparam logic [SEG_W-1:0] RST_SEG = (g == 0) ? SEG_0 : SEG_BLANK;
    // Blank when this digit and every digit above it are zero; digit 0 always shows.
    if (g == 0) begin : g_lsd
      assign blank = 1'b0;
    end else begin : g_upper
      assign blank = ~|count_q[BCD_DIGIT_W*DIGITS-1 : BCD_DIGIT_W*g];
    end
    assign hex_d = blank ? SEG_BLANK : seg_decode(count_q[BCD_DIGIT_W*g +: BCD_DIGIT_W]);
`else
    localparam logic [SEG_W-1:0] RST_SEG = SEG_0;
    assign hex_d = seg_decode(count_q[BCD_DIGIT_W*g +: BCD_DIGIT_W]);
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        hex_q <= RST_SEG;
      end else if (seg7all_on) begin
        hex_q <= SEG_ALL_ON;
      end else begin
        hex_q <= hex_d;
      end
    end

    assign hex[SEG_W*g +: SEG_W] = hex_q;
  end

endmodule
